// File: rtl/xp1_eval_arbiter.sv
// xp1_eval_arbiter: round-robin sharing of one fixed-latency 5xp1 evaluator
// among NUM_REQ requesters. Each issue carries a requester tag down a shift
// pipeline aligned with the evaluator, so every result lands in its owner's
// response register. Each requester has at most one operation in flight or held.
module xp1_eval_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned LAT     = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [7*NUM_REQ-1:0]  req_data,
   output logic [6:0]            ev_in,
   output logic                  ev_in_valid,
   input  logic [9:0]            ev_out,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [10*NUM_REQ-1:0] rsp_data,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic                  busy
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INFLIGHT,
      ST_HOLD
   } state_t;

   state_t               r_state     [NUM_REQ];
   state_t               w_state_nxt [NUM_REQ];
   logic                 w_busy_nxt;
   logic [IW-1:0]        r_rr;
   logic [IW-1:0]        w_rr_nxt;
   logic [NUM_REQ-1:0]   w_elig;
   logic [NUM_REQ-1:0]   w_grant_oh;
   logic                 w_grant_vld;
   logic [IW-1:0]        w_grant_idx;
   logic [IW:0]          w_sum;
   logic [NUM_REQ-1:0]   w_ret;
   logic [LAT:0]         r_tag_v;
   logic [LAT:0][IW-1:0] r_tag_idx;
   logic [6:0]           r_ev_in;
   logic                 r_ev_in_valid;
   logic [NUM_REQ-1:0]   r_rsp_valid;
   logic [10*NUM_REQ-1:0] r_rsp_data;
   logic                 r_busy;

   // Eligibility: idle requesters with a valid operand. Gated by rst_n so
   // req_ready is zero for the whole time reset is asserted.
   always_comb begin
      w_elig = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_elig[i] = rst_n && req_valid[i] && (r_state[i] == ST_IDLE);
      end
   end

   // Round-robin pick: first eligible requester at or after the pointer.
   always_comb begin
      w_grant_oh  = '0;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_sum       = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_sum = {1'b0, r_rr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IW+1)'(NUM_REQ);
         end
         if (!w_grant_vld && w_elig[w_sum[IW-1:0]]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = w_sum[IW-1:0];
         end
      end
      if (w_grant_vld) begin
         w_grant_oh[w_grant_idx] = 1'b1;
      end
      w_rr_nxt = (w_grant_idx == IW'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
   end

   // Decode the tag leaving the pipeline into a per-requester return strobe.
   always_comb begin
      w_ret = '0;
      if (r_tag_v[LAT]) begin
         w_ret[r_tag_idx[LAT]] = 1'b1;
      end
   end

   // Per-requester next state; busy is registered from the next state so it
   // tracks the state registers cycle for cycle.
   always_comb begin
      w_busy_nxt = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         w_state_nxt[i] = r_state[i];
         case (r_state[i])
            ST_IDLE:     if (w_grant_oh[i]) w_state_nxt[i] = ST_INFLIGHT;
            ST_INFLIGHT: if (w_ret[i])      w_state_nxt[i] = ST_HOLD;
            ST_HOLD:     if (rsp_ready[i])  w_state_nxt[i] = ST_IDLE;
            default:                        w_state_nxt[i] = ST_IDLE;
         endcase
         if (w_state_nxt[i] != ST_IDLE) begin
            w_busy_nxt = 1'b1;
         end
      end
   end

   // Requester FSMs with their registered rsp_valid and the busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            r_state[i] <= ST_IDLE;
         end
         r_rsp_valid <= '0;
         r_busy      <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            r_state[i]     <= w_state_nxt[i];
            r_rsp_valid[i] <= (w_state_nxt[i] == ST_HOLD);
         end
         r_busy <= w_busy_nxt;
      end
   end

   // Issue register toward the evaluator and round-robin pointer advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ev_in       <= '0;
         r_ev_in_valid <= 1'b0;
         r_rr          <= '0;
      end else begin
         r_ev_in_valid <= w_grant_vld;
         if (w_grant_vld) begin
            r_ev_in <= req_data[7*w_grant_idx +: 7];
            r_rr    <= w_rr_nxt;
         end
      end
   end

   // Tag pipeline: stage 0 sits beside ev_in, stage LAT beside ev_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_v   <= '0;
         r_tag_idx <= '0;
      end else begin
         r_tag_v   <= {r_tag_v[LAT-1:0], w_grant_vld};
         r_tag_idx <= {r_tag_idx[LAT-1:0], w_grant_idx};
      end
   end

   // Capture a returning result into its owner's response register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_data <= '0;
      end else if (r_tag_v[LAT]) begin
         r_rsp_data[10*r_tag_idx[LAT] +: 10] <= ev_out;
      end
   end

   assign req_ready   = w_grant_oh;
   assign ev_in       = r_ev_in;
   assign ev_in_valid = r_ev_in_valid;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign busy        = r_busy;

endmodule

// File: doc/xp1_eval_arbiter.md
Name: xp1_eval_arbiter

Overview:
- Shares one pipelined instance of the 7-input/10-output 5xp1 evaluator (path-balanced AQFP netlist, fixed latency) among NUM_REQ requesters.
- Round-robin grant, at most one issue per cycle.
- Tags each issued operand through a shift pipeline matching evaluator latency and routes each result back to its owner's response register.
- Each requester may have one evaluation in flight or held.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
LAT, 3, evaluator latency in cycles from ev_in_valid to matching ev_out (1..8)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester operand accepted this cycle
req_data  input  7*NUM_REQ  operand of requester i at [7*i+:7], bit k = xk
ev_in  output  7  operand to shared evaluator
ev_in_valid  output  1  ev_in carries a live operand
ev_out  input  10  evaluator result, bit k = yk, valid LAT cycles after ev_in_valid
rsp_valid  output  NUM_REQ  result held for requester i
rsp_data  output  10*NUM_REQ  result of requester i at [10*i+:10]
rsp_ready  input  NUM_REQ  requester i consumes its result
busy  output  1  any requester not IDLE

Behaviour:
- Clock and reset: single clock domain; clk/rst_n as fixed above. Reset is asynchronous assert, synchronous-safe deassert.
- Reset values: req_ready=0, ev_in=0, ev_in_valid=0, rsp_valid=0, rsp_data=0, busy=0, rr pointer=0, tag pipeline all invalid, every requester state=IDLE.
- Per-requester FSM:
  - IDLE -> INFLIGHT on grant.
  - INFLIGHT -> HOLD when its tag emerges from the pipeline.
  - HOLD -> IDLE when rsp_valid&rsp_ready.
- Eligibility: requester i is eligible iff state==IDLE and req_valid[i].
- Grant: among eligible requesters, the first at or after rr pointer (modulo NUM_REQ).
  - req_ready is combinational: one-hot on the granted requester, zero if none eligible.
  - On grant to g, rr pointer <= g+1 mod NUM_REQ; otherwise the pointer holds.
- Issue: ev_in and ev_in_valid are registered.
  - Cycle after grant: ev_in = granted operand, ev_in_valid = 1.
  - No grant: ev_in_valid = 0 and ev_in holds its last value.
- Tag pipeline: LAT+1 stages of {valid, index} (1 issue register stage + LAT evaluator stages), so tag k sits alongside ev_out.
  - When the last stage is valid: rsp_data[idx] <= ev_out, rsp_valid[idx] <= 1, state[idx] <= HOLD.
  - Total latency: req handshake at cycle t -> rsp_valid at t+LAT+2.
- Throughput: one issue per cycle while distinct requesters are eligible. A single requester issues at most once per LAT+2+1 cycles (the extra cycle is its rsp handshake).
- Simultaneous events:
  - Same-cycle return to i and rsp handshake by i cannot occur (i is INFLIGHT, not HOLD).
  - A return to i and a grant to another requester j in the same cycle are both performed.
  - rsp handshake by i in cycle c: i is ineligible in c and eligible from c+1.
- rsp_data[i] holds its value until the next return to i; no clearing on consume.
- Ignored inputs: ev_out when the last tag stage is invalid; req_data of non-granted requesters.
- Reset mid-operation: all in-flight tags are discarded and in-flight results are lost; the evaluator pipeline is not flushed (stale ev_out is ignored because tags are invalid).
- busy = OR over requesters of state!=IDLE, registered.

Test Plan:
- Single requester, LAT=3, stub evaluator ev_out={3'b0,ev_in} delayed 3: req0 data 7'h55 handshaken at cycle 10 -> ev_in_valid at 11, rsp_valid[0]=1 with rsp_data[0]=10'h055 at cycle 15, busy 1 from 11 until the cycle after consume.
- All 4 requesters valid from cycle 0 with data 1,2,3,4, rr=0 -> grants 0,1,2,3 on consecutive cycles; results return in the same order on cycles 5..8 with correct per-index data.
- Fairness: req0 and req2 held valid continuously, rsp_ready=1 always -> grants alternate 0,2,0,2; neither requester waits more than one other grant.
- Backpressure: req1 result held with rsp_ready[1]=0 for 20 cycles -> req_ready[1] stays 0; rsp_data[1] is stable; other requesters continue issuing at full rate.
- Reset asserted while 2 tags are in flight -> all outputs 0 immediately; after release, no rsp_valid appears from the stale evaluator outputs.
- LAT=1 and NUM_REQ=2 build: back-to-back traffic -> latency 3, no lost or duplicated results over 1000 random cycles against a scoreboard.
